// File: rtl/mem_access_unit.sv
// Unified instruction/data memory port for the multi-cycle MIPS datapath.
// Optional feature: define MISALIGN_TRAP_EN to trap accesses with addr[1:0] != 0.
module mem_access_unit #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         r_state;
  logic [31:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_idx;
  logic           r_isWrite;
  logic           r_irWrite;
  logic [31:0]    r_wdata;
  logic [3:0]     r_cnt;
  logic [31:0]    r_ir;
  logic [31:0]    r_mdr;
  logic           r_busy;
  logic           r_done;

  logic [31:0]    w_addr;
  logic [AW-1:0]  w_idx;
  logic           w_req;
  logic           w_complete;
  logic           w_unused;

  assign w_addr     = IorD ? alu_out : pc;
  assign w_idx      = w_addr[AW+1:2];
  assign w_req      = MemRead | MemWrite;
  assign w_complete = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_unused   = &{1'b0, w_addr[31:AW+2], w_addr[1:0]};

  // RAM is never reset; a reset on the completion edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && r_isWrite) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  logic w_misalign;
  assign w_misalign = (w_addr[1:0] != 2'b00);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_isWrite <= 1'b0;
      r_irWrite <= 1'b0;
      r_wdata   <= 32'd0;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_req) begin
            r_idx     <= w_idx;
            r_isWrite <= MemWrite;
            r_irWrite <= IRWrite;
            r_wdata   <= wdata;
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_cnt   <= 4'(LAT - 1);
              r_state <= BUSY;
              r_busy  <= 1'b1;
            end
`else
            r_cnt   <= 4'(LAT - 1);
            r_state <= BUSY;
            r_busy  <= 1'b1;
`endif
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            if (!r_isWrite) begin
              r_mdr <= r_mem[r_idx];
              if (r_irWrite) begin
                r_ir <= r_mem[r_idx];
              end
            end
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // Mandatory gap cycle so a level-held request is not re-issued.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ir   = r_ir;
  assign mdr  = r_mdr;
  assign busy = r_busy;
  assign done = r_done;
`ifdef MISALIGN_TRAP_EN
  assign err  = r_err;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (LAT=2 instance plus a LAT=1
// instance for the held-request case); follows MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  logic        bRead;
  logic        bWrite;
  logic [31:0] irB;
  logic [31:0] mdrB;
  logic        busyB;
  logic        doneB;
  logic        errB;

  int compareCount;
  int failCount;

  mem_access_unit #(.DEPTH(256), .AW(8), .LAT(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
    .wdata(wdata), .ir(ir), .mdr(mdr), .busy(busy), .done(done), .err(err)
  );

  mem_access_unit #(.DEPTH(256), .AW(8), .LAT(1)) dutB (
    .clk(clk), .rst(rst), .MemRead(bRead), .MemWrite(bWrite),
    .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
    .wdata(wdata), .ir(irB), .mdr(mdrB), .busy(busyB), .done(doneB), .err(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request on the LAT=2 instance, waits (bounded) for done,
  // and returns after the gap cycle. nWait counts edges after acceptance.
  task automatic applyStimulus(input logic rd, input logic wr, input logic iord,
                               input logic irw, input logic [31:0] pcv,
                               input logic [31:0] aluv, input logic [31:0] wd,
                               output int nWait, output logic busyAfterAccept);
    MemRead  = rd;
    MemWrite = wr;
    IorD     = iord;
    IRWrite  = irw;
    pc       = pcv;
    alu_out  = aluv;
    wdata    = wd;
    step();
    busyAfterAccept = busy;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    nWait    = 0;
    while (!done && nWait < 20) begin
      step();
      nWait++;
      if (busy && done) checkOutput("busyDoneExclusive", 32'(busy & done), 32'd0);
    end
    checkOutput("doneSeen", 32'(done), 32'd1);
    checkOutput("busyAtDone", 32'(busy), 32'd0);
    step();
  endtask

  task automatic writeB(input logic [31:0] pcv, input logic [31:0] wd);
    int n;
    bWrite = 1'b1;
    IorD   = 1'b0;
    pc     = pcv;
    wdata  = wd;
    step();
    bWrite = 1'b0;
    n = 0;
    while (!doneB && n < 20) begin
      step();
      n++;
    end
    checkOutput("bWriteDone", 32'(doneB), 32'd1);
    step();
  endtask

  initial begin
    int n;
    logic ba;
    logic [7:0] expBusy;
    logic [7:0] expDone;

    compareCount = 0;
    failCount    = 0;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    pc = 32'd0; alu_out = 32'd0; wdata = 32'd0; bRead = 1'b0; bWrite = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("resetIr", ir, 32'd0);
    checkOutput("resetMdr", mdr, 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetErr", 32'(err), 32'd0);

    // Preload RAM[3] through the port; a write leaves ir/mdr alone.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0, 32'h8C220004, n, ba);
    checkOutput("preloadLatency", 32'(n), 32'd2);
    checkOutput("preloadMdr", mdr, 32'd0);
    checkOutput("preloadIr", ir, 32'd0);

    // Instruction fetch.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h0, 32'h0, n, ba);
    checkOutput("fetchBusy", 32'(ba), 32'd1);
    checkOutput("fetchLatency", 32'(n), 32'd2);
    checkOutput("fetchIr", ir, 32'h8C220004);
    checkOutput("fetchMdr", mdr, 32'h8C220004);

    // Store then load at 0x40.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h40, 32'hDEADBEEF, n, ba);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, n, ba);
    checkOutput("loadMdr", mdr, 32'hDEADBEEF);
    checkOutput("loadIrKept", ir, 32'h8C220004);

    // Wrap to index 0 with read+write together: write wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h400, 32'h12345678, n, ba);
    checkOutput("prioMdrKept", mdr, 32'hDEADBEEF);
    checkOutput("prioIrKept", ir, 32'h8C220004);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, n, ba);
    checkOutput("wrapMdr", mdr, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0, 32'h0, n, ba);
    checkOutput("wrapKeepsIdx3", mdr, 32'h8C220004);

    // Reset during a write aborts it.
    MemWrite = 1'b1; IorD = 1'b1; alu_out = 32'h40; wdata = 32'hCAFEF00D;
    step();
    MemWrite = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abortBusyClr", 32'(busy), 32'd0);
    checkOutput("abortDoneClr", 32'(done), 32'd0);
    checkOutput("abortIr", ir, 32'd0);
    checkOutput("abortMdr", mdr, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, n, ba);
    checkOutput("abortIdleLatency", 32'(n), 32'd2);
    checkOutput("abortRamKept", mdr, 32'hDEADBEEF);

    // Misaligned read at pc=0x0E.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0E, 32'h0, 32'h0, n, ba);
`ifdef MISALIGN_TRAP_EN
    checkOutput("trapLatency", 32'(n), 32'd0);
    checkOutput("trapErr", 32'(err), 32'd1);
    checkOutput("trapMdrKept", mdr, 32'hDEADBEEF);
    checkOutput("trapIrKept", ir, 32'd0);
    step();
    checkOutput("trapErrSticky", 32'(err), 32'd1);
`else
    checkOutput("unalignedLatency", 32'(n), 32'd2);
    checkOutput("unalignedMdr", mdr, 32'h8C220004);
    checkOutput("unalignedIr", ir, 32'h8C220004);
    checkOutput("unalignedErr", 32'(err), 32'd0);
`endif

    // Held MemRead on the LAT=1 instance: accepts at edges 0, 3, 6.
    writeB(32'h0C, 32'h11111111);
    writeB(32'h40, 32'h22222222);
    expBusy = 8'b0100_1001;
    expDone = 8'b1001_0010;
    bRead = 1'b1; IorD = 1'b0; IRWrite = 1'b0; pc = 32'h0C;
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput($sformatf("heldBusy%0d", i), 32'(busyB), 32'(expBusy[i]));
      checkOutput($sformatf("heldDone%0d", i), 32'(doneB), 32'(expDone[i]));
      if (i == 0) pc = 32'h40;
      if (i == 1) checkOutput("heldLatchedAddr", mdrB, 32'h11111111);
      if (i == 4) checkOutput("heldSecondRead", mdrB, 32'h22222222);
    end
    bRead = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
